pipe_wb_stage: RTL and testbench
================================

// Module: pipe_wb_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage register; successor to the fixed 32-bit WB register.
//  Carries write data, destination register address and control bits with a valid/ready handshake.
//  Supports stall (backpressure), flush (bubble insertion), an optional 2-entry skid buffer and x0-write suppression.
//  Sits between the MEM stage and the register-file write port and forwarding unit.
// PARAMETERS
//  DATA_W    32  width of write-data field
//  ADDR_W     5  width of destination register address
//  CTRL_W     2  control bits; bit CTRL_REGWRITE=0, bit CTRL_MEMTOREG=1, upper bits are opaque
//  SKID       1  1: 2-entry skid buffer with registered in_ready; 0: single register, in_ready combinational
//  ZERO_SUPP  1  1: clear regwrite on capture when in_wa==0
//  CNT_W     16  width of the saturating stall counter
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       asynchronous reset, active high
//  flush      in   1       synchronous kill of all held entries
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage accepts this cycle
//  in_wdata   in   DATA_W  write data
//  in_wa      in   ADDR_W  destination register
//  in_ctrl    in   CTRL_W  control bits
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream consumes head
//  out_wdata  out  DATA_W  head write data
//  out_wa     out  ADDR_W  head destination register
//  out_ctrl   out  CTRL_W  head control; forced 0 when out_valid==0
//  stall_cnt  out  CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_wdata=0, out_wa=0, out_ctrl=0, skid empty, stall_cnt=0;
//    in_ready=1 while rst is high and after release.
//  - Accept = in_valid & in_ready; consume = out_valid & out_ready. Latency: accepted entry appears on out_* next cycle.
//  - SKID=0: in_ready = out_ready | !out_valid. Accept loads the head register; consume without accept clears out_valid.
//  - SKID=1: in_ready is a register = !skid_valid.
//    Accept while head empty or consumed -> load head.
//    Accept while head held (!out_ready) -> load skid, in_ready goes 0 next cycle.
//    Consume with skid full -> skid moves to head, skid empties, in_ready returns 1 next cycle.
//    Order is strictly FIFO; the skid entry never bypasses the head.
//  - Flush (sync): next cycle out_valid=0 and skid empty. An accept in the same cycle is discarded.
//    in_ready=1 next cycle. Flush takes priority over accept and consume.
//  - ZERO_SUPP=1: an entry captured with in_wa==0 stores ctrl[CTRL_REGWRITE]=0; other bits are unchanged.
//  - Data/addr registers load only on capture. out_ctrl is gated to 0 when !out_valid, so a bubble never writes.
//  - stall_cnt: +1 each cycle out_valid & !out_ready; holds at 2^CNT_W-1; cleared by rst only, not by flush.
//  - Reset mid-operation: all entries dropped immediately, no partial write is presented.
// STRUCTURE
//  - Shared include pipe_defs.vh: CTRL_REGWRITE, CTRL_MEMTOREG bit indices, default widths.
//  - One sub-module pipe_slot holds valid + payload {ctrl,wa,wdata} with load/clear.
//    It is instantiated as head and, under generate for SKID=1, as skid.
//  - Top contains the handshake control, ZERO_SUPP gating and the stall counter.
// TESTING
//  1. Reset: assert rst mid-stream with 2 entries held -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0, asynchronously.
//  2. Streaming: out_ready=1, push wdata 0x11,0x22,0x33 on consecutive cycles -> same values on out_wdata 1 cycle later,
//     in_ready stays 1.
//  3. Backpressure (SKID=1): out_ready=0, push A=0xA, B=0xB -> head=A, skid=B, in_ready=0, C held upstream;
//     release out_ready -> A, B, C delivered in order, no loss or duplicate.
//  4. Flush: skid full plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
//  5. x0 suppression: in_wa=0, in_ctrl=2'b11 -> out_ctrl=2'b10. Same with ZERO_SUPP=0 -> out_ctrl=2'b11.
//  6. Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15;
//     a flush does not clear it; rst does.

Source files
------------

// File: rtl/pipe_wb_stage_pkg.sv
// Shared definitions for the MEM->WB stage: control bit positions and default widths.
package pipe_wb_stage_pkg;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CTRL_W = 2;
    localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_wb_stage_slot.sv
// One pipeline slot: a valid bit plus a payload register that only changes on load.
module pipe_wb_stage_slot #(
    parameter int unsigned W = 39
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // load wins over clr so a slot can be emptied and refilled in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_wb_stage.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid entry,
// flush, x0-write suppression and a saturating stall counter.
module pipe_wb_stage
    import pipe_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned CTRL_W    = DEF_CTRL_W,
    parameter bit          SKID      = 1'b1,
    parameter bit          ZERO_SUPP = 1'b1,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [ADDR_W-1:0] in_wa,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wdata,
    output logic [ADDR_W-1:0] out_wa,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PW = CTRL_W + ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              accept;
    logic              consume;
    logic              head_valid;
    logic              head_load;
    logic              head_clr;
    logic [PW-1:0]     head_d;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     in_payload;
    logic [CTRL_W-1:0] in_ctrl_cap;
    logic [CTRL_W-1:0] head_ctrl;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign accept  = in_valid && in_ready;
    assign consume = head_valid && out_ready;

    // Writes to x0 are architecturally dead; drop regwrite so the forwarding unit ignores them too.
    always_comb begin
        in_ctrl_cap = in_ctrl;
        if (ZERO_SUPP && (in_wa == '0)) begin
            in_ctrl_cap[CTRL_REGWRITE] = 1'b0;
        end
    end

    assign in_payload = {in_ctrl_cap, in_wa, in_wdata};
    assign head_clr   = flush || consume;

    pipe_wb_stage_slot #(
        .W (PW)
    ) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clr   (head_clr),
        .d     (head_d),
        .valid (head_valid),
        .q     (head_q)
    );

    if (SKID) begin : g_skid
        logic          skid_valid;
        logic          skid_load;
        logic          skid_clr;
        logic          skid_valid_nxt;
        logic          in_ready_q;
        logic [PW-1:0] skid_q;

        // Skid only fills while the head is held, so it is always the older of nothing behind it.
        assign skid_load      = !flush && accept && head_valid && !out_ready;
        assign skid_clr       = flush || consume;
        assign head_load      = !flush && ((consume && skid_valid)
                                           || (accept && (!head_valid || out_ready)));
        assign head_d         = skid_valid ? skid_q : in_payload;
        assign skid_valid_nxt = !flush && (skid_load || (skid_valid && !consume));

        pipe_wb_stage_slot #(
            .W (PW)
        ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clr   (skid_clr),
            .d     (in_payload),
            .valid (skid_valid),
            .q     (skid_q)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= !skid_valid_nxt;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign head_load = !flush && accept;
        assign head_d    = in_payload;
        assign in_ready  = out_ready || !head_valid;
    end

    assign out_valid                      = head_valid;
    assign {head_ctrl, out_wa, out_wdata} = head_q;
    assign out_ctrl                       = head_valid ? head_ctrl : '0;

    // Flush deliberately leaves the counter alone; it tracks backpressure history, not contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (head_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Scoreboard bench: main instance (skid, x0 suppression, 4-bit counter) plus a
// single-register instance without suppression for the combinational-ready variant.
module tb_pipe_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_wa = '0;
    logic [1:0]  in_ctrl = '0;
    logic [1:0]  exp_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_wdata;
    logic [4:0]  out_wa;
    logic [1:0]  out_ctrl;
    logic [3:0]  stall_cnt;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_wdata = '0;
    logic [4:0]  b_in_wa = '0;
    logic [1:0]  b_in_ctrl = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [31:0] b_out_wdata;
    logic [4:0]  b_out_wa;
    logic [1:0]  b_out_ctrl;
    logic [7:0]  b_stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  c;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;

    always #5 clk = ~clk;

    pipe_wb_stage #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .CTRL_W    (2),
        .SKID      (1'b1),
        .ZERO_SUPP (1'b1),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wdata  (in_wdata),
        .in_wa     (in_wa),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wdata (out_wdata),
        .out_wa    (out_wa),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    pipe_wb_stage #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .CTRL_W    (2),
        .SKID      (1'b0),
        .ZERO_SUPP (1'b0),
        .CNT_W     (8)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_wdata  (b_in_wdata),
        .in_wa     (b_in_wa),
        .in_ctrl   (b_in_ctrl),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_wdata (b_out_wdata),
        .out_wa    (b_out_wa),
        .out_ctrl  (b_out_ctrl),
        .stall_cnt (b_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs are stable at negedge, so what it sees is what the next posedge acts on.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got=%0h exp=none", {out_ctrl, out_wa, out_wdata});
                end else begin
                    mon_e = sb.pop_front();
                    if ({out_ctrl, out_wa, out_wdata} !== mon_e) begin
                        errors++;
                        $display("FAIL sb_entry got=%0h exp=%0h",
                                 {out_ctrl, out_wa, out_wdata}, mon_e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({exp_ctrl, in_wa, in_wdata});
            end
        end
    end

    task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic [1:0] c,
                         input logic [1:0] ec);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_wdata = d;
        in_wa    = a;
        in_ctrl  = c;
        exp_ctrl = ec;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout got=%0h exp=accepted", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_wdata", out_wdata, 32'h0);
        chk("rst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // streaming
        out_ready = 1'b1;
        drive(32'h11, 5'd1, 2'b01, 2'b01);
        chk("stream_lat_11", out_wdata, 32'h11);
        chk("stream_ready_1", 32'(in_ready), 32'h1);
        drive(32'h22, 5'd2, 2'b01, 2'b01);
        chk("stream_lat_22", out_wdata, 32'h22);
        chk("stream_ready_2", 32'(in_ready), 32'h1);
        drive(32'h33, 5'd3, 2'b11, 2'b11);
        chk("stream_lat_33", out_wdata, 32'h33);
        @(posedge clk);
        #1;
        chk("stream_empty_valid", 32'(out_valid), 32'h0);
        chk("bubble_ctrl_gated", 32'(out_ctrl), 32'h0);

        // backpressure into the skid entry
        out_ready = 1'b0;
        drive(32'hA, 5'd4, 2'b01, 2'b01);
        drive(32'hB, 5'd5, 2'b01, 2'b01);
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        chk("bp_head_a", out_wdata, 32'hA);
        in_valid = 1'b1;
        in_wdata = 32'hC;
        in_wa    = 5'd6;
        in_ctrl  = 2'b01;
        exp_ctrl = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", 32'(in_ready), 32'h0);
        chk("bp_head_still_a", out_wdata, 32'hA);
        out_ready = 1'b1;
        drive(32'hC, 5'd6, 2'b01, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sb.size()), 32'h0);

        // flush with skid full and an input offered
        out_ready = 1'b0;
        drive(32'hD, 5'd7, 2'b01, 2'b01);
        drive(32'hE, 5'd8, 2'b01, 2'b01);
        in_valid = 1'b1;
        in_wdata = 32'hF;
        in_wa    = 5'd9;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        chk("flush_out_ctrl", 32'(out_ctrl), 32'h0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_stays_empty", 32'(out_valid), 32'h0);

        // x0 suppression
        drive(32'h55, 5'd0, 2'b11, 2'b10);
        chk("x0_supp_11", 32'(out_ctrl), 32'h2);
        drive(32'h66, 5'd3, 2'b11, 2'b11);
        chk("nonx0_keep", 32'(out_ctrl), 32'h3);
        drive(32'h77, 5'd0, 2'b01, 2'b00);
        chk("x0_supp_01", 32'(out_ctrl), 32'h0);
        chk("x0_supp_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;

        // asynchronous reset with two entries held
        out_ready = 1'b0;
        drive(32'h91, 5'd9, 2'b01, 2'b01);
        drive(32'h92, 5'd10, 2'b01, 2'b01);
        repeat (2) @(posedge clk);
        #1;
        chk("prerst_in_ready", 32'(in_ready), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_out_ctrl", 32'(out_ctrl), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("arst_out_wdata", out_wdata, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // saturating stall counter
        out_ready = 1'b0;
        drive(32'hC0, 5'd1, 2'b01, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_5", 32'(stall_cnt), 32'h5);
        repeat (15) @(posedge clk);
        #1;
        chk("cnt_sat", 32'(stall_cnt), 32'hF);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("cnt_flush_keep", 32'(stall_cnt), 32'hF);
        chk("cnt_flush_empty", 32'(out_valid), 32'h0);
        rst = 1'b1;
        #1;
        chk("cnt_rst_clear", 32'(stall_cnt), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // single-register variant, no suppression
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_wdata  = 32'hAB;
        b_in_wa     = 5'd0;
        b_in_ctrl   = 2'b11;
        #1;
        chk("b_in_ready_idle", 32'(b_in_ready), 32'h1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        chk("b_out_valid", 32'(b_out_valid), 32'h1);
        chk("b_x0_no_supp", 32'(b_out_ctrl), 32'h3);
        chk("b_out_wdata", b_out_wdata, 32'hAB);
        b_out_ready = 1'b0;
        #1;
        chk("b_in_ready_comb_lo", 32'(b_in_ready), 32'h0);
        b_out_ready = 1'b1;
        #1;
        chk("b_in_ready_comb_hi", 32'(b_in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("b_consumed", 32'(b_out_valid), 32'h0);

        chk("sb_final_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
